servo_pwm: RTL

Downstream stage of the radio receiver. Takes the 10-bit command word decoded from a receiver channel and regenerates a standard servo/ESC pulse train on a 1 MHz clock. Pulse width is 988 µs + command, so 0..1023 maps to 988..2011 µs, the inverse of the receiver decode. Commands are double-buffered and applied only at frame boundaries, so output pulses are never glitched. Optional loss-of-signal failsafe.

---
 rtl/servo_pwm.sv | 127 ++++++++++++
 1 files changed

// File: rtl/servo_pwm.sv
// servo_pwm: regenerates a servo/ESC pulse train (MIN_US + command cycles high) on a 1 MHz clock.
// Optional loss-of-signal failsafe enabled by defining SERVO_FAILSAFE_EN.
module servo_pwm #(
  parameter int unsigned PERIOD    = 20000,
  parameter int unsigned MIN_US    = 988,
  parameter int unsigned FS_FRAMES = 10,
  parameter int unsigned FS_CMD    = 0
) (
  input  logic       clk_1M,
  input  logic       rst,
  input  logic [9:0] cmd_in,
  input  logic       cmd_valid,
  output logic       pwm_out,
  output logic       frame_start,
  output logic [9:0] cmd_active,
  output logic       failsafe
);
  localparam int unsigned CNT_W = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  function automatic logic [10:0] pulse_width(input logic [9:0] cmd);
    return 11'(MIN_US) + {1'b0, cmd};
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       shadow_q, shadow_d;
  logic [9:0]       active_q, active_d;
  logic             pwm_q, pwm_d;
  logic             start_q, start_d;
  logic             run_q;
  logic             at_end, frame_first;
  logic             fail_next;

  assign at_end      = (cnt_q == LAST);
  // The first edge after reset release opens a frame just like a wrap does.
  assign frame_first = !run_q || at_end;

`ifdef SERVO_FAILSAFE_EN
  localparam int unsigned MISS_W = $clog2(FS_FRAMES + 1);

  typedef enum logic {ST_NORMAL, ST_FAILSAFE} state_e;

  state_e            state_q, state_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              seen_q, seen_d;
  logic              wrap;

  assign wrap = run_q && at_end;

  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    seen_d  = seen_q;
    if (cmd_valid) begin
      miss_d = '0;
      seen_d = 1'b1;
    end else if (wrap && !seen_q && (miss_q != MISS_W'(FS_FRAMES))) begin
      miss_d = miss_q + 1'b1;
    end
    // seen_q tracks commands within the frame now ending; a new frame starts clean.
    if (wrap) seen_d = 1'b0;
    if (cmd_valid) begin
      state_d = ST_NORMAL;
    end else if (wrap && (miss_d == MISS_W'(FS_FRAMES))) begin
      state_d = ST_FAILSAFE;
    end
  end

  always_ff @(posedge clk_1M or negedge rst) begin
    if (!rst) begin
      state_q <= ST_NORMAL;
      miss_q  <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      seen_q  <= seen_d;
    end
  end

  assign fail_next = (state_d == ST_FAILSAFE);
  assign failsafe  = (state_q == ST_FAILSAFE);
`else
  logic unused_cfg;

  assign unused_cfg = ^{FS_FRAMES, FS_CMD};
  assign fail_next  = 1'b0;
  assign failsafe   = 1'b0;
`endif

  always_comb begin
    shadow_d = cmd_valid ? cmd_in : shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q + 1'b1;
    start_d  = 1'b0;
    pwm_d    = cnt_d < CNT_W'(pulse_width(active_q));
    if (frame_first) begin
      // shadow_d already carries a same-cycle cmd_in, giving the wrap-cycle bypass.
      cnt_d    = '0;
      start_d  = 1'b1;
      pwm_d    = 1'b1;
      active_d = fail_next ? 10'(FS_CMD) : shadow_d;
    end
  end

  always_ff @(posedge clk_1M or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
      start_q  <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
      start_q  <= start_d;
      run_q    <= 1'b1;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = start_q;
  assign cmd_active  = active_q;
endmodule
